mem_ctrl: RTL and testbench

Memory controller between the instruction cache/load-store buffer and the 8-bit external RAM/IO bus. Serialises 1/2/4-byte reads and writes into one byte per cycle and assembles little-endian words. Arbitrates between ICache word fetches and LSB loads/stores. Returns a one-cycle completion pulse to the requester.

---
 rtl/mem_ctrl_pkg.sv | 33 +++
 rtl/mem_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the byte-serial memory controller: request lengths,
// controller states and the IO-window address decode.
package mem_ctrl_pkg;

    // Request length field as driven by the load/store buffer.
    localparam logic [1:0] LEN_BYTE = 2'b00;
    localparam logic [1:0] LEN_HALF = 2'b01;
    localparam logic [1:0] LEN_WORD = 2'b10;

    // Bits [17:16] of a byte address that select the UART/IO window.
    localparam logic [1:0] IO_SEL = 2'b11;

    typedef enum logic [1:0] {
        MC_IDLE  = 2'd0,
        MC_READ  = 2'd1,
        MC_WRITE = 2'd2
    } mc_state_e;

    // Number of bus bytes for a length code; the reserved code 11 is a word.
    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            LEN_BYTE: return 3'd1;
            LEN_HALF: return 3'd2;
            default:  return 3'd4;
        endcase
    endfunction

    // True when address bits [17:16] fall in the IO window.
    function automatic logic io_sel(input logic [1:0] a_hi);
        return a_hi == IO_SEL;
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller between the icache / load-store buffer and
// the 8-bit RAM/IO bus. One byte moves per enabled cycle; reads are
// assembled little-endian and zero-extended, writes are split the same way.
// The LSB wins arbitration over the icache so the ROB head never starves.
// The RAM read port is assumed to share the rdy enable, so mem_din keeps
// presenting the byte for the last issued address while rdy is low.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        clear,

    input  logic        valid_from_icache,
    input  logic [31:0] addr_from_icache,
    output logic        valid_to_icache,
    output logic [31:0] data_to_icache,

    input  logic        valid_from_lsb,
    input  logic        wr_from_lsb,
    input  logic [31:0] addr_from_lsb,
    input  logic [1:0]  len_from_lsb,
    input  logic [31:0] data_from_lsb,
    output logic        valid_to_lsb,
    output logic [31:0] data_to_lsb,

    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,

    input  logic        io_buffer_full
);

    // FSM and transfer bookkeeping
    mc_state_e   state_q;
    logic        src_lsb_q;     // 1: current transfer belongs to the LSB
    logic [31:0] base_q;        // first byte address of the transfer
    logic [31:0] wdata_q;       // store data, byte i goes out in cycle 1+i
    logic [2:0]  nbytes_q;      // 1, 2 or 4
    logic [2:0]  cnt_q;         // bytes issued (write) / cycles into read
    logic [31:0] rbuf_q;        // partially assembled read word

    // Registered bus and requester outputs
    logic [31:0] mem_a_q;
    logic [7:0]  mem_dout_q;
    logic        mem_wr_q;
    logic        v_ic_q;
    logic        v_lsb_q;
    logic [31:0] d_ic_q;
    logic [31:0] d_lsb_q;

    // Next-state helpers
    logic [2:0]  cnt_nxt;
    logic [1:0]  lane;
    logic [31:0] rbuf_d;
    logic [31:0] addr_nxt;
    logic [7:0]  wbyte_nxt;
    logic        wr_stall;
    logic        rd_last;
    logic        wr_last;
    logic        take_lsb;
    logic        take_ic;

    // Byte lane arithmetic, read assembly, IO stall and arbitration
    always_comb begin
        cnt_nxt   = cnt_q + 3'd1;
        // In read cycle cnt (>=1) mem_din carries byte cnt-1.
        lane      = cnt_q[1:0] - 2'd1;
        rbuf_d    = rbuf_q;
        rbuf_d[{lane, 3'b000} +: 8] = mem_din;
        addr_nxt  = base_q + {29'd0, cnt_nxt};
        wbyte_nxt = wdata_q[{cnt_nxt[1:0], 3'b000} +: 8];
        // A full UART buffer blocks the current IO byte; the index holds.
        wr_stall  = (state_q == MC_WRITE) && io_sel(mem_a_q[17:16]) && io_buffer_full;
        rd_last   = (cnt_q == nbytes_q);
        wr_last   = (cnt_nxt == nbytes_q);
        take_lsb  = !clear && valid_from_lsb;
        take_ic   = !clear && valid_from_icache && !valid_from_lsb;
    end

    // Controller FSM with registered bus outputs and completion pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= MC_IDLE;
            src_lsb_q  <= 1'b0;
            base_q     <= '0;
            wdata_q    <= '0;
            nbytes_q   <= '0;
            cnt_q      <= '0;
            rbuf_q     <= '0;
            mem_a_q    <= '0;
            mem_dout_q <= '0;
            mem_wr_q   <= 1'b0;
            v_ic_q     <= 1'b0;
            v_lsb_q    <= 1'b0;
            d_ic_q     <= '0;
            d_lsb_q    <= '0;
        end else if (rdy) begin
            // Completion pulses last exactly one enabled cycle.
            v_ic_q  <= 1'b0;
            v_lsb_q <= 1'b0;
            case (state_q)
                MC_IDLE: begin
                    if (take_lsb) begin
                        src_lsb_q <= 1'b1;
                        base_q    <= addr_from_lsb;
                        wdata_q   <= data_from_lsb;
                        nbytes_q  <= len_bytes(len_from_lsb);
                        cnt_q     <= '0;
                        rbuf_q    <= '0;
                        mem_a_q   <= addr_from_lsb;
                        if (wr_from_lsb) begin
                            state_q    <= MC_WRITE;
                            mem_dout_q <= data_from_lsb[7:0];
                            mem_wr_q   <= 1'b1;
                        end else begin
                            state_q    <= MC_READ;
                            mem_dout_q <= '0;
                            mem_wr_q   <= 1'b0;
                        end
                    end else if (take_ic) begin
                        state_q    <= MC_READ;
                        src_lsb_q  <= 1'b0;
                        base_q     <= addr_from_icache;
                        wdata_q    <= '0;
                        nbytes_q   <= 3'd4;
                        cnt_q      <= '0;
                        rbuf_q     <= '0;
                        mem_a_q    <= addr_from_icache;
                        mem_dout_q <= '0;
                        mem_wr_q   <= 1'b0;
                    end
                end

                MC_READ: begin
                    if (clear) begin
                        // Flush: abandon the read silently.
                        state_q <= MC_IDLE;
                        cnt_q   <= '0;
                        mem_a_q <= '0;
                    end else begin
                        if (cnt_q != 3'd0)
                            rbuf_q <= rbuf_d;
                        if (rd_last) begin
                            state_q <= MC_IDLE;
                            cnt_q   <= '0;
                            mem_a_q <= '0;
                            if (src_lsb_q) begin
                                v_lsb_q <= 1'b1;
                                d_lsb_q <= rbuf_d;
                            end else begin
                                v_ic_q <= 1'b1;
                                d_ic_q <= rbuf_d;
                            end
                        end else begin
                            cnt_q   <= cnt_nxt;
                            // Park the address once every byte has been issued.
                            mem_a_q <= (cnt_nxt < nbytes_q) ? addr_nxt : 32'd0;
                        end
                    end
                end

                MC_WRITE: begin
                    // Stores ignore clear: they are already committed.
                    if (!wr_stall) begin
                        if (wr_last) begin
                            state_q    <= MC_IDLE;
                            cnt_q      <= '0;
                            mem_a_q    <= '0;
                            mem_dout_q <= '0;
                            mem_wr_q   <= 1'b0;
                            v_lsb_q    <= 1'b1;
                        end else begin
                            cnt_q      <= cnt_nxt;
                            mem_a_q    <= addr_nxt;
                            mem_dout_q <= wbyte_nxt;
                        end
                    end
                end

                default: begin
                    state_q  <= MC_IDLE;
                    mem_a_q  <= '0;
                    mem_wr_q <= 1'b0;
                end
            endcase
        end
    end

    // Write strobe is suppressed while frozen or while an IO byte is stalled.
    assign mem_wr         = mem_wr_q && rdy && !wr_stall;
    assign mem_a          = mem_a_q;
    assign mem_dout       = mem_dout_q;
    assign valid_to_icache = v_ic_q;
    assign data_to_icache = d_ic_q;
    assign valid_to_lsb   = v_lsb_q;
    assign data_to_lsb    = d_lsb_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: cycle-by-cycle checks of fetch, arbitration,
// stores, IO stall, clear, rdy freeze and reset against hand-computed values.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst, rdy, clear;
    logic        valid_from_icache;
    logic [31:0] addr_from_icache;
    logic        valid_to_icache;
    logic [31:0] data_to_icache;
    logic        valid_from_lsb, wr_from_lsb;
    logic [31:0] addr_from_lsb, data_from_lsb;
    logic [1:0]  len_from_lsb;
    logic        valid_to_lsb;
    logic [31:0] data_to_lsb;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    logic [7:0]  ram [0:1023];
    int          n_chk = 0;
    int          n_fail = 0;

    mem_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
        .valid_from_icache(valid_from_icache), .addr_from_icache(addr_from_icache),
        .valid_to_icache(valid_to_icache), .data_to_icache(data_to_icache),
        .valid_from_lsb(valid_from_lsb), .wr_from_lsb(wr_from_lsb),
        .addr_from_lsb(addr_from_lsb), .len_from_lsb(len_from_lsb),
        .data_from_lsb(data_from_lsb), .valid_to_lsb(valid_to_lsb),
        .data_to_lsb(data_to_lsb), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
    );

    always #5 clk = ~clk;

    // RAM read port: registered, one cycle latency, frozen with rdy.
    always @(posedge clk) begin
        if (rdy) mem_din <= ram[mem_a[9:0]];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Start the next cycle; requesters drop valid when they see their pulse.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (valid_to_icache) valid_from_icache = 1'b0;
        if (valid_to_lsb)    valid_from_lsb = 1'b0;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic lsb_req(input logic wr, input logic [31:0] a, input logic [1:0] len,
                           input logic [31:0] d);
        valid_from_lsb = 1'b1;
        wr_from_lsb    = wr;
        addr_from_lsb  = a;
        len_from_lsb   = len;
        data_from_lsb  = d;
    endtask

    logic [31:0] wd;

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
        ram[10'h100] = 8'h13; ram[10'h101] = 8'h00;
        ram[10'h102] = 8'h50; ram[10'h103] = 8'h00;
        ram[10'h204] = 8'h8F;

        rst = 1'b1; rdy = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
        valid_from_icache = 1'b0; addr_from_icache = '0;
        valid_from_lsb = 1'b0; wr_from_lsb = 1'b0; addr_from_lsb = '0;
        len_from_lsb = '0; data_from_lsb = '0;
        cyc(); cyc(); smp();
        chk("rst_mem_a", mem_a, 32'h0);
        chk("rst_mem_wr", {31'd0, mem_wr}, 32'h0);
        chk("rst_vic", {31'd0, valid_to_icache}, 32'h0);
        chk("rst_vlsb", {31'd0, valid_to_lsb}, 32'h0);
        chk("rst_dic", data_to_icache, 32'h0);
        cyc(); rst = 1'b0;

        // Icache word fetch at 0x100
        cyc(); valid_from_icache = 1'b1; addr_from_icache = 32'h100;
        for (int c = 1; c <= 7; c++) begin
            cyc(); smp();
            if (c <= 4) chk("fetch_a", mem_a, 32'h100 + c - 1);
            chk("fetch_wr", {31'd0, mem_wr}, 32'h0);
            if (c == 6) begin
                chk("fetch_pulse", {31'd0, valid_to_icache}, 32'h1);
                chk("fetch_data", data_to_icache, 32'h00500013);
            end else
                chk("fetch_nopulse", {31'd0, valid_to_icache}, 32'h0);
            if (c == 7) chk("fetch_park", mem_a, 32'h0);
        end

        // Simultaneous requests: LSB byte load first, icache right after
        cyc(); valid_from_icache = 1'b1; addr_from_icache = 32'h100;
        lsb_req(1'b0, 32'h204, 2'b00, 32'h0);
        for (int c = 1; c <= 10; c++) begin
            cyc(); smp();
            if (c == 1) chk("arb_lsb_a", mem_a, 32'h204);
            if (c == 3) begin
                chk("arb_lsb_pulse", {31'd0, valid_to_lsb}, 32'h1);
                chk("arb_lsb_data", data_to_lsb, 32'h0000008F);
            end else
                chk("arb_lsb_nopulse", {31'd0, valid_to_lsb}, 32'h0);
            if (c == 4) chk("arb_ic_a", mem_a, 32'h100);
            if (c == 7) chk("arb_ic_a3", mem_a, 32'h103);
            if (c == 9) begin
                chk("arb_ic_pulse", {31'd0, valid_to_icache}, 32'h1);
                chk("arb_ic_data", data_to_icache, 32'h00500013);
            end else
                chk("arb_ic_nopulse", {31'd0, valid_to_icache}, 32'h0);
        end

        // Half store 0xBEEF to 0x200
        cyc(); lsb_req(1'b1, 32'h200, 2'b01, 32'h0000BEEF);
        for (int c = 1; c <= 4; c++) begin
            cyc(); smp();
            if (c == 1) begin
                chk("sh_a0", mem_a, 32'h200);
                chk("sh_d0", {24'd0, mem_dout}, 32'hEF);
                chk("sh_wr0", {31'd0, mem_wr}, 32'h1);
            end
            if (c == 2) begin
                chk("sh_a1", mem_a, 32'h201);
                chk("sh_d1", {24'd0, mem_dout}, 32'hBE);
                chk("sh_wr1", {31'd0, mem_wr}, 32'h1);
            end
            if (c == 3) chk("sh_wr_off", {31'd0, mem_wr}, 32'h0);
            chk("sh_pulse", {31'd0, valid_to_lsb}, (c == 3) ? 32'h1 : 32'h0);
        end

        // IO byte store with the UART buffer full in cycles 1-3
        cyc(); lsb_req(1'b1, 32'h00030000, 2'b00, 32'h00000041);
        for (int c = 1; c <= 6; c++) begin
            cyc(); io_buffer_full = (c <= 3); smp();
            if (c <= 3) begin
                chk("io_stall_wr", {31'd0, mem_wr}, 32'h0);
                chk("io_stall_a", mem_a, 32'h00030000);
            end
            if (c == 4) begin
                chk("io_wr", {31'd0, mem_wr}, 32'h1);
                chk("io_d", {24'd0, mem_dout}, 32'h41);
            end
            chk("io_pulse", {31'd0, valid_to_lsb}, (c == 5) ? 32'h1 : 32'h0);
        end
        io_buffer_full = 1'b0;

        // Clear in cycle 3 of a fetch; still-held request restarts from scratch
        cyc(); valid_from_icache = 1'b1; addr_from_icache = 32'h100;
        for (int c = 1; c <= 11; c++) begin
            cyc(); clear = (c == 3); smp();
            if (c == 4) chk("clr_idle_a", mem_a, 32'h0);
            if (c == 5) chk("clr_restart_a", mem_a, 32'h100);
            if (c == 10) begin
                chk("clr_pulse", {31'd0, valid_to_icache}, 32'h1);
                chk("clr_data", data_to_icache, 32'h00500013);
            end else
                chk("clr_nopulse", {31'd0, valid_to_icache}, 32'h0);
        end
        clear = 1'b0;

        // Clear during a word store (len code 11): all four bytes still written
        wd = 32'h11223344;
        cyc(); lsb_req(1'b1, 32'h200, 2'b11, wd);
        for (int c = 1; c <= 6; c++) begin
            cyc(); clear = (c == 2); smp();
            if (c <= 4) begin
                chk("cst_a", mem_a, 32'h200 + c - 1);
                chk("cst_d", {24'd0, mem_dout}, (wd >> (8 * (c - 1))) & 32'hFF);
                chk("cst_wr", {31'd0, mem_wr}, 32'h1);
            end
            chk("cst_pulse", {31'd0, valid_to_lsb}, (c == 5) ? 32'h1 : 32'h0);
        end
        clear = 1'b0;

        // rdy low in cycles 3-4 of a fetch: pulse moves from 6 to 8
        cyc(); valid_from_icache = 1'b1; addr_from_icache = 32'h100;
        for (int c = 1; c <= 9; c++) begin
            cyc(); rdy = !(c == 3 || c == 4); smp();
            if (c >= 3 && c <= 5) chk("rdy_hold_a", mem_a, 32'h102);
            if (c == 6) chk("rdy_a3", mem_a, 32'h103);
            if (c == 8) begin
                chk("rdy_pulse", {31'd0, valid_to_icache}, 32'h1);
                chk("rdy_data", data_to_icache, 32'h00500013);
            end else
                chk("rdy_nopulse", {31'd0, valid_to_icache}, 32'h0);
        end
        rdy = 1'b1;

        // Word store frozen by rdy in cycle 2, then reset in cycle 3
        cyc(); lsb_req(1'b1, 32'h200, 2'b10, 32'hA5A5A5A5);
        for (int c = 1; c <= 8; c++) begin
            cyc();
            rdy = (c != 2);
            rst = (c == 3);
            if (c == 3) valid_from_lsb = 1'b0;
            smp();
            if (c == 2) begin
                chk("frz_wr_gated", {31'd0, mem_wr}, 32'h0);
                chk("frz_a", mem_a, 32'h201);
            end
            if (c == 3) begin
                chk("frz_resume_wr", {31'd0, mem_wr}, 32'h1);
                chk("frz_resume_a", mem_a, 32'h201);
            end
            if (c == 4) begin
                chk("mrst_a", mem_a, 32'h0);
                chk("mrst_d", {24'd0, mem_dout}, 32'h0);
                chk("mrst_dlsb", data_to_lsb, 32'h0);
                chk("mrst_dic", data_to_icache, 32'h0);
            end
            if (c >= 4) begin
                chk("mrst_wr", {31'd0, mem_wr}, 32'h0);
                chk("mrst_nopulse", {31'd0, valid_to_lsb}, 32'h0);
            end
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
